// File: rtl/imem_stream_loader_if.sv
// ---------------------------------------------------------------------------
// imem_stream_loader_if
// Purpose : Bundles the load-stream handshake, the core fetch port and the
//           status outputs of imem_stream_loader into one interface.
// Signals :
//   ld_valid/ld_data/ld_last -> word stream from the UART/JTAG bridge
//   ld_ready                 <- loader accepts a word this cycle
//   fetch_addr               -> word address from the core
//   fetch_data/fetch_valid   <- registered read data and its valid flag
//   busy/done/overflow       <- loader status
//   load_count               <- words written by the current or last load
// Modports:
//   master : bridge/core side (drives stream and fetch address)
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface imem_stream_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   load_count;

  modport master (
    output ld_valid, ld_data, ld_last, fetch_addr,
    input  ld_ready, fetch_data, fetch_valid, busy, done, overflow, load_count
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, fetch_addr,
    output ld_ready, fetch_data, fetch_valid, busy, done, overflow, load_count
  );
endinterface

// File: rtl/imem_stream_loader.sv
// ---------------------------------------------------------------------------
// imem_stream_loader
// Purpose : Run-time reloadable instruction memory. A debounced rising edge of
//           the board switch zeroes the memory and then fills it from a
//           valid/ready word stream. Outside of clear/load the core reads it
//           through a registered fetch port.
// Ports   :
//   clk    in  sole clock, rising edge
//   rst    in  asynchronous active-low reset
//   switch in  asynchronous load-request switch
//   bus    imem_stream_loader_if.slave (stream, fetch port, status)
// ---------------------------------------------------------------------------
module imem_stream_loader #(
  parameter int DATA_W          = 32,
  parameter int DEPTH           = 32,
  parameter int ADDR_W          = $clog2(DEPTH),
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 switch,
  imem_stream_loader_if.slave  bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DONE
  } state_t;

  // -------------------------------------------------------------------------
  // Switch synchroniser, debouncer and trigger pulse
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_deb_level;
  logic                   r_deb_level_d;
  logic [CNT_W-1:0]       r_deb_cnt;
  logic                   r_trig;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], switch};
    end
  end

  // The level only flips after DEBOUNCE_CYCLES consecutive mismatching
  // samples; a single agreeing sample restarts the count. The trigger is
  // registered one cycle after the level flip.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_level   <= 1'b0;
      r_deb_level_d <= 1'b0;
      r_deb_cnt     <= '0;
      r_trig        <= 1'b0;
    end else begin
      r_deb_level_d <= r_deb_level;
      r_trig        <= r_deb_level & ~r_deb_level_d;
      if (w_sync != r_deb_level) begin
        if (r_deb_cnt == CNT_MAX) begin
          r_deb_level <= w_sync;
          r_deb_cnt   <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic                r_clr_to_load;   // CLEAR was entered from a trigger
  logic [ADDR_W:0]     r_load_count;
  logic                r_overflow;
  logic                w_start;
  logic                w_accept;
  logic                w_at_last_idx;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;

  assign w_at_last_idx = (r_load_count[ADDR_W-1:0] == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_we         = 1'b0;
    w_waddr      = r_clr_ptr;
    w_wdata      = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (r_trig) begin
          w_start      = 1'b1;
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_we = 1'b1;
        if (r_clr_ptr == LAST_IDX) begin
          w_state_next = r_clr_to_load ? ST_LOAD : ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_accept = bus.ld_valid;
        w_we     = w_accept;
        w_waddr  = r_load_count[ADDR_W-1:0];
        w_wdata  = bus.ld_data;
        if (w_accept && (bus.ld_last || w_at_last_idx)) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Clear pointer wraps to 0 after DEPTH-1 (DEPTH is a power of two), so it
  // is already positioned for the next CLEAR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_ptr     <= '0;
      r_clr_to_load <= 1'b0;
      r_load_count  <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (r_state == ST_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + 1'b1;
      end
      if (w_start) begin
        r_clr_ptr     <= '0;
        r_clr_to_load <= 1'b1;
        r_load_count  <= '0;
        r_overflow    <= 1'b0;
      end
      if (w_accept) begin
        r_load_count <= r_load_count + 1'b1;
        if (!bus.ld_last && w_at_last_idx) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Memory array: single write port (clear or load), registered fetch read.
  // Writes and reads never overlap because fetch is off during CLEAR/LOAD.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_fetch_data;
  logic              r_fetch_valid;
  logic              w_fetch_en;

  assign w_fetch_en = (r_state == ST_IDLE) || (r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_data  <= '0;
      r_fetch_valid <= 1'b0;
    end else if (w_fetch_en) begin
      r_fetch_data  <= r_mem[bus.fetch_addr];
      r_fetch_valid <= 1'b1;
    end else begin
      r_fetch_data  <= '0;
      r_fetch_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ld_ready    = (r_state == ST_LOAD);
  assign bus.busy        = (r_state == ST_CLEAR) || (r_state == ST_LOAD);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.overflow    = r_overflow;
  assign bus.load_count  = r_load_count;
  assign bus.fetch_data  = r_fetch_data;
  assign bus.fetch_valid = r_fetch_valid;

endmodule
